panda_quadin: RTL and testbench
===============================

Name: panda_quadin

Overview:
Quadrature encoder input stage. It converts raw A/B/Z encoder lines into the signed 32-bit position bus that feeds the position-compare block's posn_i.
- Provides synchronisation, glitch filtering, x4 decoding, preset load, optional Z-index reset and illegal-transition detection.
- Sits between the encoder I/O pins and the position bus.

Parameters:
FILTER_LEN, 4, consecutive cycles a synchronised input must differ from its filtered level before the change is accepted (1..255)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
a_i  in  1  raw encoder A (asynchronous)
b_i  in  1  raw encoder B (asynchronous)
z_i  in  1  raw encoder index Z (asynchronous)
SETP  in  32  preset position value
SETP_WSTB  in  1  one-cycle strobe: load SETP into position, clear error
RST_ON_Z  in  1  1 = rising filtered Z clears position to 0
posn_o  out  32  current position, two's complement, registered
err_o  out  1  sticky illegal-transition flag, registered

Behaviour:
- Reset: clk_i domain only; reset_i is asynchronous and active-high. All registers clear: posn_o=0, err_o=0, filter counters 0, primed=0.
- Sync: a_i, b_i, z_i each pass through a 2-FF synchroniser.
- Filter (per input):
  - Holds a filtered level and a counter.
  - Synchronised value == filtered level -> counter=0.
  - Otherwise counter increments; when counter reaches FILTER_LEN-1 and the input still differs, filtered level flips and counter=0.
  - Any return to the filtered level before acceptance clears the counter. Pulses shorter than FILTER_LEN cycles are rejected.
- Priming: on the first clock after reset release, primed=1. Filtered levels and the previous-state register load directly from the synchronised inputs; no count and no error on that cycle. This removes spurious counts when A/B are high at reset release.
- Decoder:
  - state={A,B} (filtered); prev=state from the previous cycle.
  - Forward (+1): 00->10->11->01->00.
  - Reverse (-1): 00->01->11->10->00.
  - prev==state: no change.
  - Both bits changed (00<->11, 10<->01): illegal. Set err_o=1, position unchanged, prev takes the new state.
- Z: rising edge of filtered Z, qualified by RST_ON_Z=1, sets posn_o=0.
- Update priority per cycle: SETP_WSTB (posn_o<=SETP, err_o<=0) > Z reset > decoder count. A count coincident with a higher-priority event is discarded.
- Arithmetic: 32-bit add/subtract modulo 2^32. 0xFFFFFFFF+1=0; 0-1=0xFFFFFFFF. No saturation.
- Latency:
  - Raw A/B edge to posn_o change = 2 (sync) + FILTER_LEN (filter) + 1 (count register) cycles; 7 at default.
  - SETP_WSTB to posn_o = 1 cycle.
- err_o is sticky: cleared only by SETP_WSTB or reset_i.
- Reset asserted mid-operation: outputs clear asynchronously; priming repeats after release.

Decomposition:
- Shared package (panda_quadin_pkg): 2-bit quadrature state encodings (Q00, Q10, Q11, Q01) and the direction constants (+1/-1/0/illegal).
- One natural sub-module: panda_quadin_filter, the synchroniser plus glitch filter with FILTER_LEN parameter and a prime input, instantiated three times (A, B, Z).
- Decoder, priority mux and position register stay in panda_quadin.

Test Plan:
1. Forward/reverse count. Reset, then 10 forward A/B cycles (40 edges, 8 clk spacing) -> posn_o=40, err_o=0. Then 5 reverse cycles -> posn_o=20. Each edge visible exactly 7 cycles after the raw change.
2. Glitch rejection. 3-cycle high pulse on a_i with b_i=0 -> posn_o unchanged. 4-cycle pulse -> posn_o +1, then -1 on the falling edge.
3. Illegal transition and clear. A and B rise in the same cycle from 00 -> err_o=1, posn_o unchanged. Then SETP=100 with SETP_WSTB -> posn_o=100 and err_o=0 one cycle later.
4. Wrap-around. SETP=0xFFFFFFFE, 3 forward edges -> posn_o=0x00000001. From 0, 1 reverse edge -> 0xFFFFFFFF.
5. Index reset and priority.
   - posn_o=37, RST_ON_Z=1, Z rising -> posn_o=0; with RST_ON_Z=0 -> posn_o stays 37.
   - Z edge and SETP_WSTB (SETP=5) in the same cycle -> posn_o=5.
6. Reset mid-operation. Hold a_i=b_i=1, assert reset_i asynchronously -> posn_o=0, err_o=0 immediately. After release with a_i=b_i=1 still held, posn_o stays 0 and err_o stays 0 for 20 cycles.

Source files
------------

// File: rtl/panda_quadin_pkg.sv
// panda_quadin_pkg: shared quadrature encodings and direction decode for the
// encoder input stage.
`timescale 1ns/1ps
package panda_quadin_pkg;

   // Filtered {A,B} quadrature state.
   typedef enum logic [1:0] {
      Q00 = 2'b00,
      Q01 = 2'b01,
      Q10 = 2'b10,
      Q11 = 2'b11
   } qstate_t;

   // Result of comparing two consecutive quadrature states.
   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_FWD  = 2'b01,
      DIR_REV  = 2'b10,
      DIR_ILL  = 2'b11
   } dir_t;

   localparam int POSN_W = 32;

   localparam logic signed [POSN_W-1:0] STEP_FWD = 32'sd1;
   localparam logic signed [POSN_W-1:0] STEP_REV = -32'sd1;

   // Forward order is 00 -> 10 -> 11 -> 01 -> 00; the inverse order is reverse.
   // Both bits changing at once cannot be attributed to a direction.
   function automatic dir_t quad_dir(input qstate_t prev, input qstate_t cur);
      dir_t d;
      d = DIR_NONE;
      if (prev != cur) begin
         if ((prev ^ cur) == 2'b11) begin
            d = DIR_ILL;
         end else begin
            case (prev)
               Q00:     d = (cur == Q10) ? DIR_FWD : DIR_REV;
               Q10:     d = (cur == Q11) ? DIR_FWD : DIR_REV;
               Q11:     d = (cur == Q01) ? DIR_FWD : DIR_REV;
               default: d = (cur == Q00) ? DIR_FWD : DIR_REV;
            endcase
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/panda_quadin_filter.sv
// panda_quadin_filter: two-flop synchroniser followed by a glitch filter that
// accepts a level change only after FILTER_LEN consecutive differing samples.
`timescale 1ns/1ps
module panda_quadin_filter
   import panda_quadin_pkg::*;
#(
   parameter int FILTER_LEN = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic raw_i,
   input  logic prime_i,
   output logic sync_o,
   output logic flt_o
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             flt_q;
   logic [CNT_W-1:0] cnt_q;

   // Synchroniser is left unreset so it keeps tracking the pin during reset;
   // priming then sees the true pin level on the first cycle after release.
   always_ff @(posedge clk_i) begin
      sync_p0 <= raw_i;
      sync_p1 <= sync_p0;
   end

   // Glitch filter: count consecutive disagreeing samples, flip on the last one.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         flt_q <= 1'b0;
         cnt_q <= '0;
      end else if (prime_i) begin
         flt_q <= sync_p1;
         cnt_q <= '0;
      end else if (sync_p1 == flt_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         flt_q <= sync_p1;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign sync_o = sync_p1;
   assign flt_o  = flt_q;

endmodule

// File: rtl/panda_quadin.sv
// panda_quadin: quadrature encoder input stage. Filters A/B/Z, decodes x4
// quadrature into a signed 32-bit position with preset load, optional Z
// index reset and a sticky illegal-transition flag.
`timescale 1ns/1ps
module panda_quadin
   import panda_quadin_pkg::*;
#(
   parameter int FILTER_LEN = 4
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        a_i,
   input  logic        b_i,
   input  logic        z_i,
   input  logic [31:0] SETP,
   input  logic        SETP_WSTB,
   input  logic        RST_ON_Z,
   output logic [31:0] posn_o,
   output logic        err_o
);

   logic                     a_sync, b_sync, z_sync;
   logic                     a_flt, b_flt, z_flt;
   logic                     primed_q;
   logic                     prime;
   qstate_t                  state;
   qstate_t                  prev_q;
   logic                     z_prev_q;
   dir_t                     dir;
   logic                     z_rise;
   logic signed [POSN_W-1:0] posn_q;
   logic signed [POSN_W-1:0] posn_d;
   logic                     err_q;
   logic                     err_d;

   assign prime = ~primed_q;

   panda_quadin_filter #(.FILTER_LEN(FILTER_LEN)) u_flt_a (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .raw_i   (a_i),
      .prime_i (prime),
      .sync_o  (a_sync),
      .flt_o   (a_flt)
   );

   panda_quadin_filter #(.FILTER_LEN(FILTER_LEN)) u_flt_b (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .raw_i   (b_i),
      .prime_i (prime),
      .sync_o  (b_sync),
      .flt_o   (b_flt)
   );

   panda_quadin_filter #(.FILTER_LEN(FILTER_LEN)) u_flt_z (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .raw_i   (z_i),
      .prime_i (prime),
      .sync_o  (z_sync),
      .flt_o   (z_flt)
   );

   assign state = qstate_t'({a_flt, b_flt});

   // Priming and previous-state tracking; the first cycle after reset loads
   // the synchronised levels so no count or error is generated.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         primed_q <= 1'b0;
         prev_q   <= Q00;
         z_prev_q <= 1'b0;
      end else if (!primed_q) begin
         primed_q <= 1'b1;
         prev_q   <= qstate_t'({a_sync, b_sync});
         z_prev_q <= z_sync;
      end else begin
         prev_q   <= state;
         z_prev_q <= z_flt;
      end
   end

   // Next position/error: preset beats Z reset beats quadrature count.
   always_comb begin
      posn_d = posn_q;
      err_d  = err_q;
      dir    = primed_q ? quad_dir(prev_q, state) : DIR_NONE;
      z_rise = primed_q & z_flt & ~z_prev_q;
      if (SETP_WSTB) begin
         posn_d = $signed(SETP);
         err_d  = 1'b0;
      end else begin
         if (dir == DIR_ILL) begin
            err_d = 1'b1;
         end
         if (z_rise && RST_ON_Z) begin
            posn_d = '0;
         end else begin
            case (dir)
               DIR_FWD: posn_d = posn_q + STEP_FWD;
               DIR_REV: posn_d = posn_q + STEP_REV;
               default: posn_d = posn_q;
            endcase
         end
      end
   end

   // Position and sticky error registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         posn_q <= '0;
         err_q  <= 1'b0;
      end else begin
         posn_q <= posn_d;
         err_q  <= err_d;
      end
   end

   assign posn_o = posn_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_panda_quadin.sv
// tb_panda_quadin: scoreboard bench for the quadrature input stage.
`timescale 1ns/1ps
module tb_panda_quadin;

   localparam int FILTER_LEN = 4;
   localparam int LAT        = 2 + FILTER_LEN + 1;

   logic        clk_i     = 1'b0;
   logic        reset_i   = 1'b1;
   logic        a_i       = 1'b0;
   logic        b_i       = 1'b0;
   logic        z_i       = 1'b0;
   logic [31:0] SETP      = '0;
   logic        SETP_WSTB = 1'b0;
   logic        RST_ON_Z  = 1'b0;
   logic [31:0] posn_o;
   logic        err_o;

   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_pass = 0;

   int          sb_due[$];
   logic [31:0] sb_posn[$];
   logic        sb_err[$];
   string       sb_tag[$];

   logic [31:0] exp_posn = '0;
   logic        exp_err  = 1'b0;

   panda_quadin #(.FILTER_LEN(FILTER_LEN)) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .z_i       (z_i),
      .SETP      (SETP),
      .SETP_WSTB (SETP_WSTB),
      .RST_ON_Z  (RST_ON_Z),
      .posn_o    (posn_o),
      .err_o     (err_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   task automatic push(input int due, input string tag);
      sb_due.push_back(due);
      sb_posn.push_back(exp_posn);
      sb_err.push_back(exp_err);
      sb_tag.push_back(tag);
   endtask

   // Pop every expectation that falls due this cycle and compare it.
   always @(negedge clk_i) begin
      string       t;
      logic [31:0] p;
      logic        e;
      while (sb_due.size() > 0 && sb_due[0] <= cyc) begin
         void'(sb_due.pop_front());
         t = sb_tag.pop_front();
         p = sb_posn.pop_front();
         e = sb_err.pop_front();
         chk({t, "_posn"}, posn_o, p);
         chk({t, "_err"}, {31'b0, err_o}, {31'b0, e});
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb_due.size() > 0; i++) tick();
      if (sb_due.size() > 0) begin
         chk("drain_timeout", 32'(sb_due.size()), 32'd0);
         sb_due.delete();
         sb_posn.delete();
         sb_err.delete();
         sb_tag.delete();
      end
   endtask

   // Change A/B now; position must hold one cycle before LAT and move at LAT.
   task automatic drive_ab(input logic na, input logic nb, input logic [31:0] delta,
                           input logic ill, input string tag);
      int c;
      c = cyc;
      push(c + LAT - 1, {tag, "_pre"});
      a_i = na;
      b_i = nb;
      exp_posn = exp_posn + delta;
      if (ill) exp_err = 1'b1;
      push(c + LAT, tag);
   endtask

   task automatic step(input logic fwd, input string tag);
      logic [1:0] s;
      logic [1:0] n;
      s = {a_i, b_i};
      if (fwd) begin
         case (s)
            2'b00:   n = 2'b10;
            2'b10:   n = 2'b11;
            2'b11:   n = 2'b01;
            default: n = 2'b00;
         endcase
      end else begin
         case (s)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
         endcase
      end
      drive_ab(n[1], n[0], fwd ? 32'd1 : 32'hFFFF_FFFF, 1'b0, tag);
      repeat (8) tick();
   endtask

   task automatic load_setp(input logic [31:0] v, input string tag);
      int c;
      c         = cyc;
      SETP      = v;
      SETP_WSTB = 1'b1;
      exp_posn  = v;
      exp_err   = 1'b0;
      push(c + 1, tag);
      tick();
      SETP_WSTB = 1'b0;
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: sim time expired, checks %0d", n_chk);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      repeat (5) tick();
      chk("rst_posn", posn_o, 32'd0);
      chk("rst_err", {31'b0, err_o}, 32'd0);
      reset_i = 1'b0;
      repeat (4) tick();

      // Forward then reverse counting
      for (int i = 0; i < 40; i++) step(1'b1, "fwd");
      drain();
      chk("t1_fwd_total", posn_o, 32'd40);
      for (int i = 0; i < 20; i++) step(1'b0, "rev");
      drain();
      chk("t1_rev_total", posn_o, 32'd20);

      // Glitch rejection: 3-cycle pulse dropped, 4-cycle pulse accepted
      c = cyc;
      push(c + LAT, "glitch3");
      push(c + LAT + 5, "glitch3_late");
      a_i = 1'b1;
      repeat (3) tick();
      a_i = 1'b0;
      drain();
      drive_ab(1'b1, 1'b0, 32'd1, 1'b0, "pulse4_rise");
      repeat (4) tick();
      drive_ab(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, "pulse4_fall");
      drain();
      chk("t2_total", posn_o, 32'd20);

      // Illegal transition then preset clears the flag
      drive_ab(1'b1, 1'b1, 32'd0, 1'b1, "illegal");
      drain();
      chk("t3_err_set", {31'b0, err_o}, 32'd1);
      load_setp(32'd100, "setp100");
      chk("t3_setp_posn", posn_o, 32'd100);
      chk("t3_setp_err", {31'b0, err_o}, 32'd0);

      // Wrap-around in both directions
      load_setp(32'hFFFF_FFFE, "setp_fffe");
      for (int i = 0; i < 3; i++) step(1'b1, "wrap_up");
      drain();
      chk("t4_wrap_up", posn_o, 32'h0000_0001);
      load_setp(32'd0, "setp0");
      step(1'b0, "wrap_dn");
      drain();
      chk("t4_wrap_dn", posn_o, 32'hFFFF_FFFF);

      // Z index reset enabled
      load_setp(32'd37, "setp37a");
      RST_ON_Z = 1'b1;
      c = cyc;
      push(c + LAT - 1, "z_clr_pre");
      z_i = 1'b1;
      exp_posn = 32'd0;
      push(c + LAT, "z_clr");
      drain();
      z_i = 1'b0;
      repeat (12) tick();

      // Z index reset disabled
      load_setp(32'd37, "setp37b");
      RST_ON_Z = 1'b0;
      c = cyc;
      push(c + LAT, "z_off");
      push(c + LAT + 3, "z_off_late");
      z_i = 1'b1;
      drain();
      z_i = 1'b0;
      repeat (12) tick();
      chk("t5_z_off", posn_o, 32'd37);

      // Z edge coincident with preset: preset wins
      RST_ON_Z = 1'b1;
      c = cyc;
      push(c + LAT - 1, "zs_pre");
      z_i = 1'b1;
      repeat (LAT - 1) tick();
      SETP      = 32'd5;
      SETP_WSTB = 1'b1;
      exp_posn  = 32'd5;
      push(c + LAT, "zs_setp");
      push(c + LAT + 2, "zs_hold");
      tick();
      SETP_WSTB = 1'b0;
      drain();
      z_i = 1'b0;
      repeat (12) tick();

      // Reset mid-operation with A=B=1 held
      for (int i = 0; i < 4 && {a_i, b_i} != 2'b11; i++) step(1'b1, "to11");
      drain();
      drive_ab(1'b0, 1'b0, 32'd0, 1'b1, "ill_a");
      drain();
      drive_ab(1'b1, 1'b1, 32'd0, 1'b1, "ill_b");
      drain();
      chk("t6_pre_posn", posn_o, exp_posn);
      chk("t6_pre_err", {31'b0, err_o}, 32'd1);
      @(posedge clk_i);
      #4;
      reset_i = 1'b1;
      #1;
      chk("t6_async_posn", posn_o, 32'd0);
      chk("t6_async_err", {31'b0, err_o}, 32'd0);
      repeat (3) tick();
      reset_i  = 1'b0;
      exp_posn = 32'd0;
      exp_err  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         chk("t6_hold_posn", posn_o, exp_posn);
         chk("t6_hold_err", {31'b0, err_o}, {31'b0, exp_err});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
